// File: rtl/ixu_pkg.sv
// ixu_pkg: shared types for the integer divide unit.
package ixu_pkg;
  localparam int DIV_OP_W = 2;
  typedef enum logic [DIV_OP_W-1:0] {DIV, DIVU, REM, REMU} div_op_t;
  typedef enum logic [1:0] {IDLE, RUN, WB} div_state_t;
  typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} core_state_t;
endpackage

// File: rtl/ixu_div.sv
// ixu_div: 32-step restoring divider on magnitudes, with single-cycle divide-by-zero and overflow results.
module ixu_div
  import ixu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_start,
  input  logic        i_unsigned,
  input  logic        i_opcode,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [31:0] o_res
);
  core_state_t r_state, w_next;
  logic [31:0] r_q, r_r, r_d;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r, r_rem;
  logic        w_a_neg, w_b_neg, w_zero, w_ovf, w_load;
  logic [31:0] w_a_abs, w_b_abs;
  logic [32:0] w_sh, w_diff;
  assign w_a_neg = ~i_unsigned & i_a[31];
  assign w_b_neg = ~i_unsigned & i_b[31];
  assign w_a_abs = w_a_neg ? -i_a : i_a;
  assign w_b_abs = w_b_neg ? -i_b : i_b;
  assign w_zero  = i_b == '0;
  assign w_ovf   = ~i_unsigned & (i_a == 32'h8000_0000) & (i_b == '1);
  assign w_load  = (r_state == C_IDLE) & i_start & ~i_flush;
  assign w_sh    = {r_r, r_q[31]};
  assign w_diff  = w_sh - {1'b0, r_d};
  assign o_done  = r_state == C_DONE;
  assign o_res   = r_rem ? (r_neg_r ? -r_r : r_r) : (r_neg_q ? -r_q : r_q);
  always_comb begin
    w_next = r_state;
    if (i_flush) w_next = C_IDLE;
    else if (r_state == C_IDLE) w_next = i_start ? ((w_zero | w_ovf) ? C_DONE : C_BUSY) : C_IDLE;
    else if (r_state == C_BUSY) w_next = (r_cnt == 5'd31) ? C_DONE : C_BUSY;
    else w_next = C_IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= C_IDLE;
    else r_state <= w_next;
  // special cases preload the final quotient/remainder so the sign fix-up is a no-op
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_rem   <= 1'b0;
    end else if (w_load) begin
      r_rem   <= i_opcode;
      r_cnt   <= '0;
      r_d     <= w_b_abs;
      r_q     <= w_zero ? '1 : w_ovf ? 32'h8000_0000 : w_a_abs;
      r_r     <= w_zero ? i_a : '0;
      r_neg_q <= ~w_zero & ~w_ovf & (w_a_neg ^ w_b_neg);
      r_neg_r <= ~w_zero & ~w_ovf & w_a_neg;
    end else if (r_state == C_BUSY) begin
      r_cnt <= r_cnt + 5'd1;
      r_q   <= {r_q[30:0], ~w_diff[32]};
      r_r   <= w_diff[32] ? w_sh[31:0] : w_diff[31:0];
    end
endmodule

// File: rtl/ixu_div_unit.sv
// ixu_div_unit: issue wrapper and writeback stage around ixu_div with a one-entry result memo.
module ixu_div_unit
  import ixu_pkg::*;
#(
  parameter int TAG_W = 6,
  parameter int ROB_W = 5
) (
  input  logic             core_clock_i,
  input  logic             core_reset_n_i,
  input  logic             core_flush_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [1:0]       issue_op_i,
  input  logic [31:0]      issue_a_i,
  input  logic [31:0]      issue_b_i,
  input  logic [TAG_W-1:0] issue_tag_i,
  input  logic [ROB_W-1:0] issue_rob_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_data_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic [ROB_W-1:0] wb_rob_o,
  output logic             busy_o
);
  div_state_t r_state, w_next;
  div_op_t    r_op, r_memo_op;
  logic [31:0] r_a, r_b, r_data, r_memo_a, r_memo_b, r_memo_res, w_res;
  logic [TAG_W-1:0] r_tag;
  logic [ROB_W-1:0] r_rob;
  logic r_memo_v, w_accept, w_hit, w_start, w_done, w_capture, w_core_flush;
  assign issue_ready_o = core_reset_n_i & ~core_flush_i & (r_state == IDLE);
  assign w_accept      = issue_valid_i & issue_ready_o;
  assign w_hit         = r_memo_v & (issue_a_i == r_memo_a) & (issue_b_i == r_memo_b) & (div_op_t'(issue_op_i) == r_memo_op);
  assign w_start       = w_accept & ~w_hit;
  assign w_capture     = (r_state == RUN) & w_done & ~core_flush_i;
  assign w_core_flush  = core_flush_i | ~core_reset_n_i;
  assign wb_valid_o    = r_state == WB;
  assign busy_o        = r_state != IDLE;
  assign wb_data_o     = r_data;
  assign wb_tag_o      = r_tag;
  assign wb_rob_o      = r_rob;
  ixu_div u_div (
    .i_clk      (core_clock_i),
    .i_rst_n    (core_reset_n_i),
    .i_flush    (w_core_flush),
    .i_start    (w_start),
    .i_unsigned (issue_op_i[0]),
    .i_opcode   (issue_op_i[1]),
    .i_a        (issue_a_i),
    .i_b        (issue_b_i),
    .o_done     (w_done),
    .o_res      (w_res)
  );
  always_comb begin
    w_next = r_state;
    w_next = core_flush_i ? IDLE :
             w_accept ? (w_hit ? WB : RUN) :
             w_capture ? WB :
             (r_state == WB && wb_ready_i) ? IDLE : r_state;
  end
  always_ff @(posedge core_clock_i or negedge core_reset_n_i)
    if (!core_reset_n_i) r_state <= IDLE;
    else r_state <= w_next;
  // the memo is written only from a completed core run, never from a flushed one
  always_ff @(posedge core_clock_i or negedge core_reset_n_i)
    if (!core_reset_n_i) begin
      r_op       <= DIV;
      r_a        <= '0;
      r_b        <= '0;
      r_tag      <= '0;
      r_rob      <= '0;
      r_data     <= '0;
      r_memo_v   <= 1'b0;
      r_memo_op  <= DIV;
      r_memo_a   <= '0;
      r_memo_b   <= '0;
      r_memo_res <= '0;
    end else if (w_accept) begin
      r_op  <= div_op_t'(issue_op_i);
      r_a   <= issue_a_i;
      r_b   <= issue_b_i;
      r_tag <= issue_tag_i;
      r_rob <= issue_rob_i;
      if (w_hit) r_data <= r_memo_res;
    end else if (w_capture) begin
      r_data     <= w_res;
      r_memo_v   <= 1'b1;
      r_memo_op  <= r_op;
      r_memo_a   <= r_a;
      r_memo_b   <= r_b;
      r_memo_res <= w_res;
    end
endmodule
